// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned MIN_DIV_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned clamp_div(
    input int unsigned div,
    input int unsigned min
  );
    return (div < min) ? min : div;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control and output bundle of the programmable clock divider.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             en_i;
  logic [CNT_W-1:0] div_i;
  logic             clk_o;
  logic             tick_o;
  logic [CNT_W-1:0] div_o;
  logic             run_o;

  modport master (
    output en_i,
    output div_i,
    input  clk_o,
    input  tick_o,
    input  div_o,
    input  run_o
  );

  modport slave (
    input  en_i,
    input  div_i,
    output clk_o,
    output tick_o,
    output div_o,
    output run_o
  );

endinterface

// File: rtl/clk_div_prog_half_stretch.sv
// Negedge stage and output gate: odd ratios get a half-cycle
// trimmed off the high phase so duty stays at 50%.
module clk_half_stretch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_p,
  input  logic i_odd,
  output logic o_clk
);

  logic r_n;

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_n <= 1'b0;
    end else begin
      r_n <= i_p;
    end
  end

  // i_odd only changes at a period start, while i_p rises
  assign o_clk = i_p & (r_n | ~i_odd);

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider,
// fully synchronous to clk_i.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  clk_div_if.slave bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_p;
  logic             r_tick;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic             w_p_nxt;
  logic             w_tick_nxt;

  logic [CNT_W-1:0] w_divc;
  logic [CNT_W:0]   w_half;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_bnd;
  logic             w_clk;

  assign w_divc = CNT_W'(clamp_div(32'(bus.div_i), MIN_DIV));

  // one extra bit so an all-ones ratio does not wrap
  assign w_half    = ({1'b0, r_div} + 1'b1) >> 1;
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  assign w_bnd     = (r_cnt == r_div - CNT_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= CNT_W'(MIN_DIV);
      r_p     <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_p     <= w_p_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_p_nxt     = r_p;
    w_tick_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_p_nxt   = 1'b0;
        if (bus.en_i) begin
          w_state_nxt = RUN;
          w_div_nxt   = w_divc;
          w_p_nxt     = 1'b1;
          w_tick_nxt  = 1'b1;
        end
      end
      RUN: begin
        unique case (1'b1)
          !w_bnd: begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
            w_p_nxt   = (w_cnt_inc < w_half);
          end
          w_bnd && bus.en_i: begin
            w_cnt_nxt  = '0;
            w_div_nxt  = w_divc;
            w_p_nxt    = 1'b1;
            w_tick_nxt = 1'b1;
          end
          w_bnd && !bus.en_i: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_p_nxt     = 1'b0;
          end
        endcase
      end
    endcase
  end

  clk_half_stretch u_stretch (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_p   (r_p),
    .i_odd (r_div[0]),
    .o_clk (w_clk)
  );

  assign bus.clk_o  = w_clk;
  assign bus.tick_o = r_tick;
  assign bus.div_o  = r_div;
  assign bus.run_o  = (r_state == RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised and directed bench for clk_div_prog against a
// half-cycle waveform model of the divided clock.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  clk_div_if #(.CNT_W(W)) bus ();

  clk_div_prog #(.CNT_W(W), .MIN_DIV(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model: running flag, cycle index in period, period length
  bit m_run = 1'b0;
  int m_pos = 0;
  int m_n   = 2;

  function automatic int clampn(int d);
    return (d < 2) ? 2 : d;
  endfunction

  // expected level at half-cycle t of an N-cycle period
  function automatic bit hi(int n, int t);
    if (n % 2 == 0) return t < n;
    return (t >= 1) && (t <= n);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0;
      m_pos = 0;
      m_n   = 2;
    end else if (!m_run) begin
      if (bus.en_i) begin
        m_run = 1'b1;
        m_pos = 0;
        m_n   = clampn(int'(bus.div_i));
      end
    end else if (m_pos == m_n - 1) begin
      if (bus.en_i) begin
        m_pos = 0;
        m_n   = clampn(int'(bus.div_i));
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_pos++;
    end
  end

  logic [10:0] o_p, e_p;
  logic        o_n, e_n;

  // sample one cycle: posedge+1 and negedge+1
  task automatic step();
    @(posedge clk); #1;
    o_p = {bus.clk_o, bus.tick_o, bus.run_o, bus.div_o};
    e_p = {m_run && hi(m_n, 2 * m_pos),
           m_run && (m_pos == 0), m_run, 8'(m_n)};
    @(negedge clk); #1;
    o_n = bus.clk_o;
    e_n = m_run && hi(m_n, 2 * m_pos + 1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.en_i = 1'b0;
    bus.div_i = 8'd9;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.clk_o, bus.tick_o, bus.run_o, bus.div_o} !== 11'h002) begin
      failures++;
      $display("FAIL reset got=%h exp=%h",
        {bus.clk_o, bus.tick_o, bus.run_o, bus.div_o}, 11'h002);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n} || o_p[8] !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
    end
  endtask

  task automatic test_n2();
    do_reset();
    bus.div_i = 8'd2;
    bus.en_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n}) begin
        failures++;
        $display("FAIL n2 cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
    end
  endtask

  task automatic test_n3();
    int hic = 0;
    int tk = 0;
    do_reset();
    bus.div_i = 8'd3;
    bus.en_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n}) begin
        failures++;
        $display("FAIL n3 cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
      hic += int'(o_p[10]) + int'(o_n);
      tk += int'(o_p[9]);
    end
    checks++;
    if (hic != 30 || tk != 10) begin
      failures++;
      $display("FAIL n3_duty got=%0d/%0d exp=30/10", hic, tk);
    end
  endtask

  task automatic test_ratio_change();
    int first_len = 0;
    do_reset();
    bus.div_i = 8'd4;
    bus.en_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n}) begin
        failures++;
        $display("FAIL ratio cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
      if (i == 1) bus.div_i = 8'd7;
      if (i > 0 && o_p[9] === 1'b1 && first_len == 0) first_len = i;
    end
    checks++;
    if (first_len != 4) begin
      failures++;
      $display("FAIL ratio_len got=%0d exp=4", first_len);
    end
  endtask

  task automatic test_stop();
    do_reset();
    bus.div_i = 8'd6;
    bus.en_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n}) begin
        failures++;
        $display("FAIL stop cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
      if (i == 1) bus.en_i = 1'b0;
    end
    checks++;
    if ({bus.clk_o, bus.tick_o, bus.run_o} !== 3'b000) begin
      failures++;
      $display("FAIL stop_end got=%b exp=000",
        {bus.clk_o, bus.tick_o, bus.run_o});
    end
  endtask

  task automatic test_clamp();
    int ds[3] = '{0, 1, 255};
    for (int k = 0; k < 3; k++) begin
      int n = clampn(ds[k]);
      int hic = 0;
      do_reset();
      bus.div_i = 8'(ds[k]);
      bus.en_i = 1'b1;
      for (int i = 0; i < 2 * n + 2; i++) begin
        step();
        checks++;
        if ({o_p, o_n} !== {e_p, e_n}) begin
          failures++;
          $display("FAIL clamp d=%0d cyc=%0d got=%h exp=%h",
            ds[k], i, {o_p, o_n}, {e_p, e_n});
        end
        if (i < n) hic += int'(o_p[10]) + int'(o_n);
      end
      checks++;
      if (hic != n) begin
        failures++;
        $display("FAIL clamp_duty d=%0d got=%0d exp=%0d",
          ds[k], hic, n);
      end
    end
  endtask

  task automatic test_reset_mid_high();
    bit seen = 1'b0;
    do_reset();
    bus.div_i = 8'd5;
    bus.en_i = 1'b1;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n}) begin
        failures++;
        $display("FAIL rst_mid cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
      seen = (o_n === 1'b1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (!seen || {bus.clk_o, bus.run_o} !== 2'b00) begin
      failures++;
      $display("FAIL rst_drop got=%b seen=%0d exp=00",
        {bus.clk_o, bus.run_o}, seen);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n}) begin
        failures++;
        $display("FAIL rst_restart cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    bus.div_i = 8'd5;
    bus.en_i = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      checks++;
      if ({o_p, o_n} !== {e_p, e_n}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
          i, {o_p, o_n}, {e_p, e_n});
      end
      if ($urandom_range(0, 7) == 0) bus.en_i = ~bus.en_i;
      if ($urandom_range(0, 3) == 0)
        bus.div_i = 8'($urandom_range(0, 12));
    end
  endtask

  initial begin
    bus.en_i = 1'b0;
    bus.div_i = 8'd2;
    test_reset();
    test_n2();
    test_n3();
    test_ratio_change();
    test_stop();
    test_clamp();
    test_reset_mid_high();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
